// File: rtl/mips_cpu_definitions.sv
// Shared MIPS core definitions: access sizes, bus sequencer states, request info.
package mips_cpu_definitions;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      STORE,
      RESP
   } bus_state_t;

   // Per-access attributes latched when a data request leaves IDLE
   typedef struct packed {
      mem_size_t  size;
      logic       sgn;
      logic [1:0] lo;
   } acc_info_t;

   // Natural-alignment check for a data access; unknown sizes are treated as word
   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] lo);
      case (size)
         BYTE:    return 1'b0;
         HALF:    return lo[0];
         default: return (lo != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mips_cpu_bus_lane.sv
// Byte-lane steering: byteenable, store replication, load extraction/extension.
module mips_cpu_bus_lane
   import mips_cpu_definitions::*;
(
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  byteenable_c,
   output logic [31:0] wdata_c,
   output logic [31:0] rdata_c
);

   logic [7:0]  b_sel;
   logic [15:0] h_sel;

   // Lane k carries bits [8k+7:8k]; sub-word loads pick their lane then extend
   always_comb begin
      byteenable_c = 4'b1111;
      wdata_c      = wdata;
      rdata_c      = rdata;
      b_sel        = rdata[{addr_lo, 3'b000} +: 8];
      h_sel        = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (mem_size_t'(size))
         BYTE: begin
            byteenable_c = 4'b0001 << addr_lo;
            wdata_c      = {4{wdata[7:0]}};
            rdata_c      = {{24{is_signed & b_sel[7]}}, b_sel};
         end
         HALF: begin
            byteenable_c = 4'b0011 << addr_lo;
            wdata_c      = {2{wdata[15:0]}};
            rdata_c      = {{16{is_signed & h_sel[15]}}, h_sel};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_cpu_bus_ctrl.sv
// Avalon-MM sequencer/arbiter sharing one master port between fetch and load/store.
module mips_cpu_bus_ctrl
   import mips_cpu_definitions::*;
#(
   parameter int unsigned MAX_WAIT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic [31:0] fetch_addr,
   output logic        fetch_done,
   output logic [31:0] fetch_data,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   output logic        mem_err,
   output logic        busy,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   localparam int unsigned WCNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   bus_state_t        state;
   acc_info_t         acc;
   logic [WCNT_W-1:0] wait_cnt;

   mem_size_t   ln_size;
   logic        ln_signed;
   logic [1:0]  ln_lo;
   logic [3:0]  ln_be;
   logic [31:0] ln_wdata;
   logic [31:0] ln_rdata;
   logic        mis_mem;
   logic        mis_fetch;
   logic        wd_hit;

   // Lane logic sees the live request in IDLE and the latched one during a transfer
   always_comb begin
      ln_size   = acc.size;
      ln_signed = acc.sgn;
      ln_lo     = acc.lo;
      if (state == IDLE) begin
         ln_size   = mem_size_t'(mem_size);
         ln_signed = mem_signed;
         ln_lo     = mem_addr[1:0];
      end
   end

   mips_cpu_bus_lane u_lane (
      .size         (ln_size),
      .is_signed    (ln_signed),
      .addr_lo      (ln_lo),
      .wdata        (mem_wdata),
      .rdata        (readdata),
      .byteenable_c (ln_be),
      .wdata_c      (ln_wdata),
      .rdata_c      (ln_rdata)
   );

   assign mis_mem   = is_misaligned(mem_size_t'(mem_size), mem_addr[1:0]);
   assign mis_fetch = (fetch_addr[1:0] != 2'b00);
   assign wd_hit    = (MAX_WAIT != 0) && (wait_cnt == WCNT_W'(MAX_WAIT - 32'd1));

   // Sequencer: arbitration in IDLE, stall/watchdog in bus states, one-cycle done in RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         acc        <= '0;
         wait_cnt   <= '0;
         fetch_done <= 1'b0;
         fetch_data <= '0;
         mem_done   <= 1'b0;
         mem_rdata  <= '0;
         mem_err    <= 1'b0;
         busy       <= 1'b0;
         address    <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
         byteenable <= '0;
      end else begin
         fetch_done <= 1'b0;
         mem_done   <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req) begin
                  acc.size <= mem_size_t'(mem_size);
                  acc.sgn  <= mem_signed;
                  acc.lo   <= mem_addr[1:0];
                  busy     <= 1'b1;
                  if (mis_mem) begin
                     state    <= RESP;
                     mem_done <= 1'b1;
                     mem_err  <= 1'b1;
                  end else begin
                     address    <= {mem_addr[31:2], 2'b00};
                     byteenable <= ln_be;
                     writedata  <= ln_wdata;
                     read       <= ~mem_we;
                     write      <= mem_we;
                     wait_cnt   <= '0;
                     state      <= mem_we ? STORE : LOAD;
                  end
               end else if (fetch_req) begin
                  busy <= 1'b1;
                  if (mis_fetch) begin
                     state      <= RESP;
                     fetch_done <= 1'b1;
                     mem_err    <= 1'b1;
                  end else begin
                     address    <= {fetch_addr[31:2], 2'b00};
                     byteenable <= 4'b1111;
                     read       <= 1'b1;
                     write      <= 1'b0;
                     wait_cnt   <= '0;
                     state      <= FETCH;
                  end
               end
            end
            FETCH, LOAD, STORE: begin
               if (!waitrequest || wd_hit) begin
                  read  <= 1'b0;
                  write <= 1'b0;
                  state <= RESP;
                  if (state == FETCH) fetch_done <= 1'b1;
                  else                mem_done   <= 1'b1;
                  if (waitrequest) begin
                     mem_err <= 1'b1;
                  end else if (state == FETCH) begin
                     fetch_data <= readdata;
                  end else if (state == LOAD) begin
                     mem_rdata <= ln_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt + WCNT_W'(1);
               end
            end
            RESP: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_err <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_bus_ctrl.sv
// Directed bench for mips_cpu_bus_ctrl with a scoreboard of expected completions.
module tb_mips_cpu_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_done;
   logic [31:0] fetch_data;
   logic        mem_req;
   logic        mem_we;
   logic [1:0]  mem_size;
   logic        mem_signed;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        mem_err;
   logic        busy;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   typedef struct {
      logic        is_fetch;
      logic        chk_data;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] model_rdata = '0;

   always #5 clk = ~clk;

   mips_cpu_bus_ctrl #(.MAX_WAIT(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_done  (fetch_done),
      .fetch_data  (fetch_data),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_size    (mem_size),
      .mem_signed  (mem_signed),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_done    (mem_done),
      .mem_rdata   (mem_rdata),
      .mem_err     (mem_err),
      .busy        (busy),
      .address     (address),
      .read        (read),
      .write       (write),
      .waitrequest (waitrequest),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic is_fetch, input logic chk_data, input logic [31:0] data,
                       input logic err);
      exp_t e;
      e.is_fetch = is_fetch;
      e.chk_data = chk_data;
      e.data     = data;
      e.err      = err;
      sb_q.push_back(e);
   endtask

   // Compare the current done pulse against the oldest expected completion
   task automatic sb_check(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_done"}, {30'd0, fetch_done, mem_done}, e.is_fetch ? 32'd2 : 32'd1);
         chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, e.err});
         if (e.chk_data)
            chk({tag, "_data"}, e.is_fetch ? fetch_data : mem_rdata, e.data);
      end
   endtask

   // One data access with a given number of stall cycles; checks bus pins every cycle
   task automatic mem_xfer(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic [31:0] exp_rdata,
                           input int waits);
      mem_req     = 1'b1;
      mem_we      = we;
      mem_size    = size;
      mem_signed  = sgn;
      mem_addr    = addr;
      mem_wdata   = wdata;
      readdata    = rd;
      waitrequest = (waits > 0);
      if (!we) model_rdata = exp_rdata;
      push(1'b0, !we, exp_rdata, 1'b0);
      for (int i = 0; i <= waits; i++) begin
         tick();
         chk({tag, "_read"}, {31'd0, read}, {31'd0, !we});
         chk({tag, "_write"}, {31'd0, write}, {31'd0, we});
         chk({tag, "_addr"}, address, {addr[31:2], 2'b00});
         chk({tag, "_be"}, {28'd0, byteenable}, {28'd0, exp_be});
         if (we) chk({tag, "_wdata"}, writedata, exp_wd);
         if (i == waits) waitrequest = 1'b0;
      end
      tick();
      chk({tag, "_lat"}, {31'd0, mem_done}, 32'd1);
      sb_check(tag);
      mem_req = 1'b0;
      tick();
      chk({tag, "_pulse"}, {31'd0, mem_done}, 32'd0);
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   // Wait for a done pulse within a cycle budget, then score it
   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (!(fetch_done || mem_done) && n < budget) begin
         tick();
         n++;
      end
      if (fetch_done || mem_done) sb_check(tag);
      else chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      reset       = 1'b0;
      fetch_req   = 1'b0;
      fetch_addr  = '0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_size    = 2'b00;
      mem_signed  = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      waitrequest = 1'b0;
      readdata    = '0;
      tick();
      tick();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rw", {30'd0, read, write}, 32'd0);
      chk("rst_addr", address, 32'd0);
      chk("rst_be", {28'd0, byteenable}, 32'd0);
      chk("rst_wd", writedata, 32'd0);
      chk("rst_fdata", fetch_data, 32'd0);
      chk("rst_rdata", mem_rdata, 32'd0);
      chk("rst_done", {29'd0, fetch_done, mem_done, mem_err}, 32'd0);
      reset = 1'b1;
      tick();

      // Zero-wait fetch: read in cycle 1, done in cycle 2
      fetch_req  = 1'b1;
      fetch_addr = 32'hBFC0_0000;
      readdata   = 32'h8C02_0004;
      push(1'b1, 1'b1, 32'h8C02_0004, 1'b0);
      tick();
      chk("f0_read", {31'd0, read}, 32'd1);
      chk("f0_be", {28'd0, byteenable}, 32'hF);
      chk("f0_addr", address, 32'hBFC0_0000);
      tick();
      chk("f0_lat", {31'd0, fetch_done}, 32'd1);
      sb_check("f0");
      fetch_req = 1'b0;
      tick();
      chk("f0_pulse", {31'd0, fetch_done}, 32'd0);

      // Sub-word and word accesses over the lanes
      mem_xfer("lb_s", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_00AA, 4'b1000,
               32'h0, 32'hFFFF_FF80, 3);
      mem_xfer("sh", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hFFFF_1234, 32'h0, 4'b1100,
               32'h1234_1234, 32'h0, 0);
      mem_xfer("lh_u", 1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0, 32'h89AB_0000, 4'b1100,
               32'h0, 32'h0000_89AB, 0);
      mem_xfer("lb_u", 1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0, 32'h1234_F6AA, 4'b0010,
               32'h0, 32'h0000_00F6, 2);
      mem_xfer("lw", 1'b0, 2'b10, 1'b1, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 4'b1111,
               32'h0, 32'hDEAD_BEEF, 1);
      mem_xfer("sb", 1'b1, 2'b00, 1'b0, 32'h0000_6003, 32'h1234_565A, 32'h0, 4'b1000,
               32'h5A5A_5A5A, 32'h0, 0);
      mem_xfer("lh_s", 1'b0, 2'b01, 1'b1, 32'h0000_7000, 32'h0, 32'h0000_8001, 4'b0011,
               32'h0, 32'hFFFF_8001, 0);

      // Simultaneous requests: data first, fetch right after RESP
      mem_req    = 1'b1;
      mem_we     = 1'b0;
      mem_size   = 2'b10;
      mem_addr   = 32'h0000_0100;
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_0200;
      readdata   = 32'h1111_1111;
      model_rdata = 32'h1111_1111;
      push(1'b0, 1'b1, 32'h1111_1111, 1'b0);
      push(1'b1, 1'b1, 32'h2222_2222, 1'b0);
      tick();
      chk("arb_addr", address, 32'h0000_0100);
      tick();
      sb_check("arb_mem");
      mem_req  = 1'b0;
      readdata = 32'h2222_2222;
      tick();
      chk("arb_gap", {31'd0, read}, 32'd0);
      tick();
      chk("arb_fread", {31'd0, read}, 32'd1);
      chk("arb_faddr", address, 32'h0000_0200);
      wait_done("arb_fetch", 4);
      fetch_req = 1'b0;
      tick();

      // Misaligned word load and fetch: no bus cycle, err with done
      mem_req  = 1'b1;
      mem_size = 2'b10;
      mem_addr = 32'h0000_0006;
      push(1'b0, 1'b1, model_rdata, 1'b1);
      tick();
      chk("mis_read", {31'd0, read}, 32'd0);
      sb_check("mis_lw");
      mem_req = 1'b0;
      tick();
      chk("mis_errclr", {30'd0, mem_done, mem_err}, 32'd0);
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_0002;
      push(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      chk("misf_read", {31'd0, read}, 32'd0);
      sb_check("mis_f");
      fetch_req = 1'b0;
      tick();

      // Watchdog: read held 8 stalled cycles, then abort with rdata unchanged
      mem_req     = 1'b1;
      mem_we      = 1'b0;
      mem_size    = 2'b10;
      mem_addr    = 32'h0000_0040;
      readdata    = 32'h5555_5555;
      waitrequest = 1'b1;
      push(1'b0, 1'b1, model_rdata, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("wd_read", {31'd0, read}, 32'd1);
      end
      tick();
      chk("wd_drop", {31'd0, read}, 32'd0);
      sb_check("wd");
      mem_req     = 1'b0;
      waitrequest = 1'b0;
      tick();

      // Reset during a stall: outputs drop before the next clock, no done
      fetch_req   = 1'b1;
      fetch_addr  = 32'h0000_0300;
      waitrequest = 1'b1;
      tick();
      tick();
      chk("rs_pre", {31'd0, read}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("rs_async", {29'd0, read, write, busy}, 32'd0);
      chk("rs_rdata", mem_rdata, 32'd0);
      fetch_req   = 1'b0;
      waitrequest = 1'b0;
      tick();
      chk("rs_nodone", {30'd0, fetch_done, mem_done}, 32'd0);
      reset = 1'b1;
      tick();
      chk("rs_nodone2", {30'd0, fetch_done, mem_done}, 32'd0);
      fetch_req  = 1'b1;
      fetch_addr = 32'h0000_0400;
      readdata   = 32'hCAFE_F00D;
      push(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
      wait_done("rs_fetch", 6);
      fetch_req = 1'b0;
      tick();
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
